ascon_share_masker: RTL and testbench
=====================================

# ascon_share_masker

Producer side of the masked ASCON datapath: turns an unmasked W-bit word into (d+1) Boolean shares and supplies the fresh DOM-AND randomness that the masked S-box layer consumes alongside it. The share and fresh-bit formats match the masked S-box inputs. An internal xorshift32 PRNG fills a randomness pool over several cycles, and valid/ready handshakes run on both sides. The block sits between the unmasked load path and the first masked permutation round.

## Interface
- `d`, 2: masking order.
- `NUM_SHARES`, d+1: number of shares.
- `W`, 64: data word width (one ASCON lane).
- `FRESH_W`, (d+1)*d/2: fresh bits emitted per word for the DOM-AND stage.
- `POOL_W`, d*W+FRESH_W: random bits consumed per word (131 at defaults).
- `F`, ceil(POOL_W/32): fill cycles per word (5 at defaults).

- `clk`  in  1: single clock, all logic on its rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `seed_valid`  in  1: load `seed` into the PRNG this cycle.
- `seed`  in  32: PRNG seed. Value 0 is replaced by 32'h0000_0001.
- `mask_en`  in  1: 1 = random shares; 0 = unmasked debug mode.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: block can accept a word.
- `in_data`  in  W: unmasked word.
- `out_valid`  out  1: share bundle is valid.
- `out_ready`  in  1: consumer accepts the bundle.
- `out_shares`  out  NUM_SHARES*W: share k occupies `out_shares[k*W +: W]`.
- `out_fresh`  out  FRESH_W: fresh bits paired with this bundle.

## Operation
- The PRNG is a 32-bit xorshift: x ^= x<<13; x ^= x>>17; x ^= x<<5. All shifts are logical and truncated to 32 bits.
- The pool is a POOL_W-bit register.
  - Fill step c (c = 0..F-1): PRNG steps to x' and the pool is written with `pool[32c +: 32] <= x'`.
  - Bits beyond POOL_W are dropped.
- FSM states:
  - SEED: reset state. No fill activity and `in_ready` = 0. Leaves only on `seed_valid`.
  - FILL: counter c runs 0..F-1, one step per cycle. After step F-1 the FSM moves to ARMED.
  - ARMED: pool is full; waits for the input handshake.
- `in_ready` = (state == ARMED) && !seed_valid && (!out_valid || out_ready).
- Accept is `in_valid && in_ready`. On accept:
  - Random slice r_k = `pool[(k-1)*W +: W]` for k = 1..d.
  - Share k (k ≥ 1) = r_k when `mask_en` = 1, otherwise 0.
  - Share 0 = `in_data` XOR share 1 XOR … XOR share d.
  - `out_fresh` <= `pool[d*W +: FRESH_W]`, or 0 when `mask_en` = 0.
  - `out_valid` <= 1, state → FILL with c = 0.
- Every pool bit is used for at most one word. A new word is never accepted before a full refill.
- Output register: when `out_valid && out_ready` with no accept in the same cycle, `out_valid` <= 0.
  - Data stays stable while `out_valid && !out_ready`.
  - Accept and drain in the same cycle load the new bundle and keep `out_valid` = 1.
- `seed_valid` in any state:
  - PRNG <= seed, or 1 when seed = 0.
  - State → FILL with c = 0. The old pool is discarded.
  - No accept can occur that cycle. `out_valid` and the output data are unaffected.
- `mask_en` is sampled only on the accept cycle.

## Timing
- Reset values: state SEED, PRNG 32'h0000_0001, pool 0, c 0, `out_valid` 0, `out_shares` 0, `out_fresh` 0, `in_ready` 0.
- Seed sampled at cycle t: FILL during t+1..t+F, ARMED and `in_ready` high at t+F+1 (cycle 6 for t=0 at defaults).
- Accept at cycle t: `out_valid` high at t+1; the next accept is possible no earlier than t+F+1.
  - Peak throughput is 1 word per F+1 cycles.
- Back-pressure: refill proceeds while the output is stalled. ARMED with `out_valid && !out_ready` holds `in_ready` at 0.
- `rst_n` low at any point, including mid-FILL or with `out_valid` = 1: all state returns to reset values next edge and the pending bundle is lost.

## Test plan
- Reset, then seed = 1 at cycle 0:
  - `in_ready` = 0 through cycle 5 and rises at cycle 6.
  - After the first fill step, `pool[31:0]` = 32'h0004_2021.
- Seed 0 versus seed 1: output sequences are bit-identical for the same 4 input words.
- `in_data` = 64'hDEAD_BEEF_0123_4567 with `mask_en` = 1:
  - XOR of the 3 shares equals `in_data`.
  - Shares 1 and 2 and `out_fresh` match a software xorshift32 model bit-exact.
  - Shares 1 and 2 are non-zero.
- `mask_en` = 0 with the same word: share 0 = 64'hDEAD_BEEF_0123_4567, shares 1 and 2 = 0, `out_fresh` = 0.
- Back-to-back `in_valid` with `out_ready` stuck at 0 for 20 cycles:
  - Exactly one accept, and the output stays stable.
  - Releasing `out_ready` allows the second accept in that same cycle.
- Corner events:
  - `rst_n` pulsed at FILL c = 3 → all outputs return to reset values.
  - `seed_valid` asserted together with `in_valid` in ARMED → no accept, and the refill restarts.

Source files
------------

// File: rtl/ascon_share_masker.sv
// ascon_share_masker: splits an unmasked ASCON lane into Boolean shares and
// supplies the fresh DOM-AND bits, drawing all randomness from a pool that an
// internal xorshift32 PRNG refills over F cycles after every accepted word.
module ascon_share_masker #(
  parameter int d          = 2,
  parameter int NUM_SHARES = d + 1,
  parameter int W          = 64,
  parameter int FRESH_W    = (d + 1) * d / 2,
  parameter int POOL_W     = d * W + FRESH_W,
  parameter int F          = (POOL_W + 31) / 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    seed_valid,
  input  logic [31:0]             seed,
  input  logic                    mask_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W-1:0]            in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_SHARES*W-1:0] out_shares,
  output logic [FRESH_W-1:0]      out_fresh
);

  localparam int CW = $clog2(F + 1);

  typedef enum logic [1:0] {
    SEED,
    FILL,
    ARMED
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CW-1:0]           fill_cnt;
  logic [CW-1:0]           cnt_next;
  logic                    fill_step;
  logic [31:0]             prng;
  logic [31:0]             prng_next;
  logic [POOL_W-1:0]       pool;
  logic [POOL_W-1:0]       pool_next;
  logic [NUM_SHARES*W-1:0] shares_next;
  logic [FRESH_W-1:0]      fresh_next;
  logic [W-1:0]            share0;
  logic                    accept;

  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // A seed load blocks accept so a stale pool never leaks into a new bundle;
  // a stalled output also blocks accept so the pending bundle is never lost.
  assign in_ready  = (state == ARMED) && !seed_valid && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign prng_next = xorshift32(prng);

  // Place the freshly stepped PRNG word into the 32-bit pool slot for this fill step
  always_comb begin
    pool_next = pool;
    for (int i = 0; i < POOL_W; i++) begin
      if ((i >> 5) == int'(fill_cnt)) begin
        pool_next[i] = prng_next[i[4:0]];
      end
    end
  end

  // Build the share bundle from the pool; debug mode zeroes all randomness
  always_comb begin
    shares_next = '0;
    fresh_next  = '0;
    if (mask_en) begin
      for (int k = 1; k <= d; k++) begin
        shares_next[k*W +: W] = pool[(k-1)*W +: W];
      end
      fresh_next = pool[d*W +: FRESH_W];
    end
    share0 = in_data;
    for (int k = 1; k <= d; k++) begin
      share0 = share0 ^ shares_next[k*W +: W];
    end
    shares_next[W-1:0] = share0;
  end

  // Next-state logic: seeding always restarts the fill, accept starts a refill
  always_comb begin
    state_next = state;
    cnt_next   = fill_cnt;
    fill_step  = 1'b0;
    if (seed_valid) begin
      state_next = FILL;
      cnt_next   = '0;
    end else begin
      case (state)
        SEED: begin
          state_next = SEED;
        end
        FILL: begin
          fill_step = 1'b1;
          if (fill_cnt == CW'(F - 1)) begin
            state_next = ARMED;
            cnt_next   = '0;
          end else begin
            cnt_next = fill_cnt + CW'(1);
          end
        end
        ARMED: begin
          if (accept) begin
            state_next = FILL;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = SEED;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // State and fill counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= SEED;
      fill_cnt <= '0;
    end else begin
      state    <= state_next;
      fill_cnt <= cnt_next;
    end
  end

  // PRNG and randomness pool: reseed on demand, otherwise step once per fill cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prng <= 32'h0000_0001;
      pool <= '0;
    end else if (seed_valid) begin
      prng <= (seed == 32'h0) ? 32'h0000_0001 : seed;
    end else if (fill_step) begin
      prng <= prng_next;
      pool <= pool_next;
    end
  end

  // Output bundle register: load on accept, hold while stalled, drop after drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_shares <= '0;
      out_fresh  <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_shares <= shares_next;
      out_fresh  <= fresh_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ascon_share_masker.sv
// tb_ascon_share_masker: drives seeds and words into the masker and compares
// every bundle with a software xorshift32 pool model.
module tb_ascon_share_masker;

  localparam int D  = 2;
  localparam int NS = D + 1;
  localparam int W  = 64;
  localparam int FW = 3;
  localparam int PW = 131;
  localparam int F  = 5;

  logic            clk;
  logic            rst_n;
  logic            seed_valid;
  logic [31:0]     seed;
  logic            mask_en;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic            out_valid;
  logic            out_ready;
  logic [NS*W-1:0] out_shares;
  logic [FW-1:0]   out_fresh;

  int nVectors;
  int nMiscompares;

  logic [31:0]     mPrng;
  logic [PW-1:0]   mPool;
  logic [NS*W-1:0] lastShares;
  logic [FW-1:0]   lastFresh;
  logic [NS*W-1:0] runA [4];
  logic [FW-1:0]   runAFresh [4];
  logic [W-1:0]    words [4];

  ascon_share_masker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_valid (seed_valid),
    .seed       (seed),
    .mask_en    (mask_en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_shares (out_shares),
    .out_fresh  (out_fresh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    nVectors++;
    if (obs !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] v;
    v = x;
    v = v ^ (v << 13);
    v = v ^ (v >> 17);
    v = v ^ (v << 5);
    return v;
  endfunction

  task automatic modelRefill();
    logic [F*32-1:0] wide;
    for (int c = 0; c < F; c++) begin
      mPrng = xs(mPrng);
      wide[c*32 +: 32] = mPrng;
    end
    mPool = wide[PW-1:0];
  endtask

  task automatic modelSeed(input logic [31:0] s);
    mPrng = (s == 32'h0) ? 32'h1 : s;
    modelRefill();
  endtask

  task automatic computeExpected(input logic [W-1:0] data, input logic m,
                                 output logic [NS*W-1:0] sh, output logic [FW-1:0] fr);
    logic [W-1:0] r1;
    logic [W-1:0] r2;
    r1 = m ? mPool[63:0] : '0;
    r2 = m ? mPool[127:64] : '0;
    sh = {r2, r1, data ^ r1 ^ r2};
    fr = m ? mPool[130:128] : '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n      = 1'b0;
    seed_valid = 1'b0;
    seed       = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    mask_en    = 1'b1;
    out_ready  = 1'b1;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic seedDut(input logic [31:0] s);
    seed_valid = 1'b1;
    seed       = s;
    cycle();
    seed_valid = 1'b0;
    modelSeed(s);
  endtask

  // Offer one word, wait (bounded) for the handshake, then check the bundle
  task automatic applyStimulus(input logic [W-1:0] data, input logic m);
    int cnt;
    logic [NS*W-1:0] sh;
    logic [FW-1:0]   fr;
    in_valid = 1'b1;
    in_data  = data;
    mask_en  = m;
    cnt = 0;
    @(negedge clk);
    while (!in_ready && cnt < 40) begin
      cycle();
      @(negedge clk);
      cnt++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 192'(in_ready), 192'(1));
      cycle();
      in_valid = 1'b0;
      return;
    end
    cycle();
    in_valid = 1'b0;
    computeExpected(data, m, sh, fr);
    modelRefill();
    @(negedge clk);
    checkOutput("out_valid", 192'(out_valid), 192'(1));
    checkOutput("shares", 192'(out_shares), 192'(sh));
    checkOutput("fresh", 192'(out_fresh), 192'(fr));
    lastShares = out_shares;
    lastFresh  = out_fresh;
    cycle();
  endtask

  initial begin
    int accepts;
    logic [NS*W-1:0] sh2;
    logic [FW-1:0]   fr2;
    nVectors     = 0;
    nMiscompares = 0;
    words[0] = 64'h0123_4567_89AB_CDEF;
    words[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    words[2] = 64'h0;
    words[3] = 64'hA5A5_5A5A_C3C3_3C3C;

    // reset values and seed-to-ready latency
    doReset();
    @(negedge clk);
    checkOutput("rst_in_ready", 192'(in_ready), 192'(0));
    checkOutput("rst_out_valid", 192'(out_valid), 192'(0));
    checkOutput("rst_shares", 192'(out_shares), 192'(0));
    checkOutput("rst_fresh", 192'(out_fresh), 192'(0));
    cycle();
    seed_valid = 1'b1;
    seed       = 32'h1;
    @(negedge clk);
    checkOutput("rdy_cycle0", 192'(in_ready), 192'(0));
    cycle();
    seed_valid = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      if (t == 2) checkOutput("pool_step0", 192'(dut.pool[31:0]), 192'(32'h0004_2021));
      checkOutput($sformatf("rdy_cycle%0d", t), 192'(in_ready), 192'(t == 6));
      cycle();
    end
    modelSeed(32'h1);

    // known word, masked then debug mode
    applyStimulus(64'hDEAD_BEEF_0123_4567, 1'b1);
    checkOutput("share_xor", 192'(lastShares[63:0] ^ lastShares[127:64] ^ lastShares[191:128]),
                192'(64'hDEAD_BEEF_0123_4567));
    checkOutput("share1_nonzero", 192'(lastShares[127:64] != 64'h0), 192'(1));
    checkOutput("share2_nonzero", 192'(lastShares[191:128] != 64'h0), 192'(1));
    applyStimulus(64'hDEAD_BEEF_0123_4567, 1'b0);
    checkOutput("dbg_share0", 192'(lastShares[63:0]), 192'(64'hDEAD_BEEF_0123_4567));
    checkOutput("dbg_share12", 192'(lastShares[191:64]), 192'(0));
    checkOutput("dbg_fresh", 192'(lastFresh), 192'(0));

    // seed 0 must behave exactly like seed 1
    doReset();
    seedDut(32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(words[i], 1'b1);
      runA[i]      = lastShares;
      runAFresh[i] = lastFresh;
    end
    doReset();
    seedDut(32'h1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(words[i], 1'b1);
      checkOutput($sformatf("seed01_sh%0d", i), 192'(lastShares), 192'(runA[i]));
      checkOutput($sformatf("seed01_fr%0d", i), 192'(lastFresh), 192'(runAFresh[i]));
    end

    // back-pressure: one accept, stable output, release allows immediate accept
    out_ready = 1'b0;
    applyStimulus(64'h1111_2222_3333_4444, 1'b1);
    in_valid = 1'b1;
    in_data  = 64'h5555_6666_7777_8888;
    mask_en  = 1'b1;
    accepts  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_valid && in_ready) accepts++;
      checkOutput("bp_stable", 192'(out_shares), 192'(lastShares));
      cycle();
    end
    checkOutput("bp_accepts", 192'(accepts), 192'(0));
    checkOutput("bp_valid", 192'(out_valid), 192'(1));
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_rdy", 192'(in_ready), 192'(1));
    cycle();
    in_valid = 1'b0;
    computeExpected(64'h5555_6666_7777_8888, 1'b1, sh2, fr2);
    modelRefill();
    @(negedge clk);
    checkOutput("bp_second_valid", 192'(out_valid), 192'(1));
    checkOutput("bp_second_sh", 192'(out_shares), 192'(sh2));
    checkOutput("bp_second_fr", 192'(out_fresh), 192'(fr2));
    cycle();

    // seed together with in_valid in ARMED: no accept, refill restarts
    accepts = 0;
    while (!in_ready && accepts < 40) begin
      cycle();
      @(negedge clk);
      accepts++;
    end
    cycle();
    @(negedge clk);
    checkOutput("armed_before_seed", 192'(in_ready), 192'(1));
    cycle();
    in_valid   = 1'b1;
    in_data    = 64'hCAFE_F00D_0000_0001;
    seed_valid = 1'b1;
    seed       = 32'h1234_5678;
    @(negedge clk);
    checkOutput("seed_blocks_rdy", 192'(in_ready), 192'(0));
    cycle();
    seed_valid = 1'b0;
    in_valid   = 1'b0;
    modelSeed(32'h1234_5678);
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      if (t == 1) checkOutput("seed_no_accept", 192'(out_valid), 192'(0));
      checkOutput($sformatf("reseed_rdy%0d", t), 192'(in_ready), 192'(t == 6));
      cycle();
    end
    applyStimulus(64'hCAFE_F00D_0000_0002, 1'b1);

    // reset pulse in the middle of a refill
    applyStimulus(64'h0F0F_0F0F_F0F0_F0F0, 1'b1);
    cycle();
    cycle();
    checkOutput("fill_cnt_3", 192'(dut.fill_cnt), 192'(3));
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_valid", 192'(out_valid), 192'(0));
    checkOutput("midrst_shares", 192'(out_shares), 192'(0));
    checkOutput("midrst_fresh", 192'(out_fresh), 192'(0));
    checkOutput("midrst_pool", 192'(dut.pool), 192'(0));
    cycle();
    in_valid = 1'b1;
    accepts  = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (in_ready) accepts++;
      cycle();
    end
    in_valid = 1'b0;
    checkOutput("seed_state_idle", 192'(accepts), 192'(0));

    // randomized words, masks and idle/stall gaps
    seedDut($urandom);
    for (int i = 0; i < 25; i++) begin
      logic [W-1:0] data;
      int gap;
      data = {$urandom, $urandom};
      gap  = $urandom_range(0, 6);
      for (int g = 0; g < gap; g++) begin
        out_ready = 1'($urandom_range(0, 1));
        cycle();
      end
      out_ready = 1'b1;
      applyStimulus(data, 1'($urandom_range(0, 1)));
      checkOutput("rand_xor", 192'(lastShares[63:0] ^ lastShares[127:64] ^ lastShares[191:128]),
                  192'(data));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
